prom_load_ctrl: RTL and testbench
=================================

# prom_load_ctrl

Sequencing controller for the 16×8 program memory: owns the memory's write and read strobes, loads 16 bytes from a byte-stream source, verifies them by checksum read-back, then hands the memory to the CPU for run mode. Sits between the front-panel/serial program source, the CPU's MAR/control word, and the memory block's `addr`, `data_in`, `low_load`, `low_o_en` and `clr` pins.

## Interface
- `ADDR_W`, 4, memory address width; the memory depth is 2^ADDR_W = 16 words.
- `DATA_W`, 8, memory word width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `low_clr` in 1: asynchronous, active-low reset.
- `prog_start` in 1: one-cycle request to start a programming session.
- `byte_in` in DATA_W: program byte from the source.
- `byte_valid` in 1: `byte_in` valid.
- `byte_ready` out 1: the controller accepts a byte this cycle.
- `cpu_addr` in ADDR_W: CPU MAR value, used in RUN only.
- `cpu_low_o_en` in 1: CPU memory output enable, active-low, used in RUN only.
- `mem_addr` out ADDR_W: to memory `addr`.
- `mem_data_in` out DATA_W: to memory `data_in`.
- `mem_low_load` out 1: to memory `low_load`, active-low.
- `mem_low_o_en` out 1: to memory `low_o_en`, active-low.
- `mem_clr` out 1: to memory `clr`, active-high.
- `mem_data_out` in DATA_W: memory read bus.
- `busy` out 1: a programming session is in progress (CLEAR, WRITE or VERIFY).
- `done` out 1: verify passed; the CPU owns the memory.
- `error` out 1: verify failed.
- `run_en` out 1: CPU may fetch; identical to `done`.

## Operation
- States: IDLE, CLEAR, WRITE, VERIFY, RUN, ERROR. Reset enters IDLE.
- IDLE: waits for `prog_start`, which moves it to CLEAR.
- CLEAR: lasts one cycle.
  - `mem_clr`=1.
  - The write counter, read counter and both checksums are cleared.
  - Next state is WRITE.
- WRITE:
  - `byte_ready`=1.
  - `mem_addr` = write counter; `mem_data_in` = `byte_in`.
  - `mem_low_load` = ~`byte_valid`, which is combinational, so the write lands on the accepting edge.
  - On each accept (`byte_valid`&`byte_ready`): the counter increments and `wsum` = (`wsum`+`byte_in`) mod 256.
  - The accept at address 15 moves the block to VERIFY.
  - With `byte_valid`=0, the block holds indefinitely with no write.
- VERIFY:
  - `mem_addr` = read counter; `mem_low_o_en`=0.
  - Each cycle, `rsum` = (`rsum`+`mem_data_out`) mod 256 and the read counter increments.
  - After address 15 is sampled, the block compares the final `rsum` against `wsum`: equal goes to RUN, otherwise to ERROR.
- RUN:
  - `mem_addr`=`cpu_addr` and `mem_low_o_en`=`cpu_low_o_en`, both combinational pass-through.
  - `mem_low_load`=1.
  - `done`=`run_en`=1.
  - `prog_start` moves the block to CLEAR, which reprograms the memory.
- ERROR: `error`=1 and the memory is idle. `prog_start` moves the block to CLEAR.
- Outside WRITE, VERIFY and RUN:
  - `mem_low_load`=1, `mem_low_o_en`=1.
  - `mem_addr`=0, `mem_data_in`=0.
- `prog_start` is ignored in CLEAR, WRITE and VERIFY.
- All sums are 8-bit and wrap, with no carry out. Counters wrap 15→0 and the wrap is the transition condition.

## Timing
- Reset values (while `low_clr`=0, asynchronously):
  - State IDLE.
  - `mem_addr`=0, `mem_data_in`=0.
  - `mem_low_load`=1, `mem_low_o_en`=1, `mem_clr`=0.
  - `byte_ready`=0, `busy`=0, `done`=0, `error`=0, `run_en`=0.
- `prog_start` sampled at edge t: CLEAR occupies cycle t+1 and WRITE starts at cycle t+2.
- Minimum session is 1 + 16 + 16 = 33 cycles from the first CLEAR cycle to RUN. `done` rises in the cycle after the last verify read.
- Memory read is combinational from its registers, so a VERIFY sample is taken in the same cycle the address is driven.
- Reset mid-session returns to IDLE immediately. Memory contents are then partial and undefined, and `done` stays 0 until a full session passes.
- `byte_valid` asserted outside WRITE: the byte is not accepted and no write occurs.

## Structure
- Shared include `prom_ctrl_defs.vh`:
  - State encodings: IDLE=0, CLEAR=1, WRITE=2, VERIFY=3, RUN=4, ERROR=5, in 3 bits.
  - `MEM_DEPTH`=16.
- One sub-module, `counter_4bit`: synchronous clear, count enable, async active-low reset, wrap flag. It is instantiated twice, once as the write counter and once as the read counter.
- Checksums and the FSM stay in the top module.

## Test plan
- **Reset:** `low_clr`=0 mid-WRITE at address 7 → all outputs at their reset values within the same cycle; IDLE after release; `done`=0.
- **Load and verify:** `prog_start`, then bytes 0x01..0x10 back-to-back → `mem_clr` high for 1 cycle; 16 writes at addresses 0..15; `wsum`=0x88; RUN at cycle 33; `done`=`run_en`=1.
- **Stalled source:** same bytes with `byte_valid` deasserted 3 cycles between each → no writes while stalled; address advances only on accept; same final memory contents; `done`=1.
- **Verify failure:** memory model corrupts address 5 (0x06 read as 0x07) → `error`=1; `done`=0; `mem_low_load`=1. A subsequent `prog_start` with a clean model reaches RUN.
- **RUN pass-through:** in RUN, `cpu_addr`=0xA with `cpu_low_o_en`=0 → `mem_addr`=0xA and `mem_low_o_en`=0 in the same cycle; `mem_data_out` equals byte 0x0B; `mem_low_load` stays 1.
- **Start ignored:** `prog_start` pulsed during VERIFY → ignored, session completes normally. `prog_start` pulsed in RUN → CLEAR next cycle; `done` falls.

Source files
------------

// File: rtl/prom_load_ctrl_pkg.sv
// Shared types and constants for the program-memory load controller.
package prom_load_ctrl_pkg;

  localparam int unsigned AddrW    = 4;
  localparam int unsigned DataW    = 8;
  localparam int unsigned MemDepth = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StWrite  = 3'd2,
    StVerify = 3'd3,
    StRun    = 3'd4,
    StError  = 3'd5
  } state_e;

  // 8-bit checksum accumulate; carry out is discarded.
  function automatic logic [DataW-1:0] checksum_add(input logic [DataW-1:0] acc,
                                                    input logic [DataW-1:0] val);
    return acc + val;
  endfunction

endpackage

// File: rtl/prom_load_ctrl_if.sv
// Memory-side bus between the load controller (master) and the 16x8 program memory (slave).
interface prom_load_ctrl_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_low_load;
  logic              mem_low_o_en;
  logic              mem_clr;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output mem_addr,
    output mem_data_in,
    output mem_low_load,
    output mem_low_o_en,
    output mem_clr,
    input  mem_data_out
  );

  modport slave (
    input  mem_addr,
    input  mem_data_in,
    input  mem_low_load,
    input  mem_low_o_en,
    input  mem_clr,
    output mem_data_out
  );

endinterface

// File: rtl/prom_load_ctrl_counter_4bit.sv
// 4-bit address counter with synchronous clear, count enable and a wrap flag.
module counter_4bit (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic       wrap_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // High on the cycle whose increment takes the count from 15 back to 0.
  assign wrap_o  = en_i && (count_q == 4'hF);

endmodule

// File: rtl/prom_load_ctrl.sv
// Program-memory sequencer: clear, load 16 bytes, verify by checksum read-back, then hand to CPU.
module prom_load_ctrl
  import prom_load_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic              clk,
  input  logic              low_clr,
  input  logic              prog_start,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_low_o_en,
  prom_load_ctrl_if.master  mem,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              run_en
);

  state_e state_q, state_d;

  logic [3:0]        wr_cnt, rd_cnt;
  logic              wr_wrap, rd_wrap;
  logic              cnt_clr, wr_en, rd_en;
  logic [DATA_W-1:0] wsum_q, wsum_d, rsum_q, rsum_d;

  assign cnt_clr = (state_q == StClear);
  assign wr_en   = (state_q == StWrite) && byte_valid;
  assign rd_en   = (state_q == StVerify);

  counter_4bit u_wr_cnt (
    .clk_i   (clk),
    .rst_ni  (low_clr),
    .clr_i   (cnt_clr),
    .en_i    (wr_en),
    .count_o (wr_cnt),
    .wrap_o  (wr_wrap)
  );

  counter_4bit u_rd_cnt (
    .clk_i   (clk),
    .rst_ni  (low_clr),
    .clr_i   (cnt_clr),
    .en_i    (rd_en),
    .count_o (rd_cnt),
    .wrap_o  (rd_wrap)
  );

  // Read sum including the word sampled this cycle; the final compare needs it.
  always_comb begin
    wsum_d = wsum_q;
    rsum_d = rsum_q;
    if (cnt_clr) begin
      wsum_d = '0;
      rsum_d = '0;
    end else begin
      if (wr_en) wsum_d = checksum_add(wsum_q, byte_in);
      if (rd_en) rsum_d = checksum_add(rsum_q, mem.mem_data_out);
    end
  end

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      state_q <= StIdle;
      wsum_q  <= '0;
      rsum_q  <= '0;
    end else begin
      state_q <= state_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (prog_start) state_d = StClear;
      StClear:  state_d = StWrite;
      StWrite:  if (wr_wrap) state_d = StVerify;
      StVerify: if (rd_wrap) state_d = (rsum_d == wsum_q) ? StRun : StError;
      StRun:    if (prog_start) state_d = StClear;
      StError:  if (prog_start) state_d = StClear;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_ready       = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    error            = 1'b0;
    mem.mem_addr     = '0;
    mem.mem_data_in  = '0;
    mem.mem_low_load = 1'b1;
    mem.mem_low_o_en = 1'b1;
    mem.mem_clr      = 1'b0;
    unique case (state_q)
      StClear: begin
        busy        = 1'b1;
        mem.mem_clr = 1'b1;
      end
      StWrite: begin
        busy             = 1'b1;
        byte_ready       = 1'b1;
        mem.mem_addr     = ADDR_W'(wr_cnt);
        mem.mem_data_in  = byte_in;
        // Combinational strobe so the write lands on the accepting edge.
        mem.mem_low_load = ~byte_valid;
      end
      StVerify: begin
        busy             = 1'b1;
        mem.mem_addr     = ADDR_W'(rd_cnt);
        mem.mem_low_o_en = 1'b0;
      end
      StRun: begin
        done             = 1'b1;
        mem.mem_addr     = cpu_addr;
        mem.mem_low_o_en = cpu_low_o_en;
      end
      StError: error = 1'b1;
      default: ;
    endcase
  end

  assign run_en = done;

endmodule

// File: tb/tb_prom_load_ctrl.sv
// Bench for prom_load_ctrl with a behavioural 16x8 memory and session-level checksum model.
module tb_prom_load_ctrl;
  import prom_load_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       low_clr = 1'b0;
  logic       prog_start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic [3:0] cpu_addr = 4'h0;
  logic       cpu_low_o_en = 1'b1;
  logic       byte_ready, busy, done, error, run_en;

  int vectors = 0;
  int miscompares = 0;

  prom_load_ctrl_if #(.ADDR_W(4), .DATA_W(8)) mem_if ();

  prom_load_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk          (clk),
    .low_clr      (low_clr),
    .prog_start   (prog_start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .cpu_addr     (cpu_addr),
    .cpu_low_o_en (cpu_low_o_en),
    .mem          (mem_if.master),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .run_en       (run_en)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write and clear, combinational read, optional fault at address 5.
  logic [7:0] mem [16];
  logic       corrupt = 1'b0;
  logic [7:0] rd_word;

  always @(posedge clk) begin
    if (mem_if.mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (!mem_if.mem_low_load) begin
      mem[mem_if.mem_addr] <= mem_if.mem_data_in;
    end
  end

  always_comb begin
    rd_word = mem[mem_if.mem_addr];
    if (corrupt && mem_if.mem_addr == 4'd5) rd_word = rd_word + 8'd1;
  end

  assign mem_if.mem_data_out = mem_if.mem_low_o_en ? 8'h00 : rd_word;

  logic [7:0] stim [16];

  typedef struct {
    int max_gap;
    bit fixed_gap;
    bit ramp;
    bit corrupt;
    bit pulse_verify;
  } sess_t;

  typedef struct {
    logic [3:0] addr;
    logic       oen;
    logic [3:0] exp_addr;
    logic       exp_oen;
    logic [7:0] exp_data;
  } run_vec_t;

  sess_t    sessions [8];
  run_vec_t run_vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " mem_addr"}, 32'(mem_if.mem_addr), 0);
    chk({tag, " mem_data_in"}, 32'(mem_if.mem_data_in), 0);
    chk({tag, " mem_low_load"}, 32'(mem_if.mem_low_load), 1);
    chk({tag, " mem_low_o_en"}, 32'(mem_if.mem_low_o_en), 1);
    chk({tag, " mem_clr"}, 32'(mem_if.mem_clr), 0);
    chk({tag, " byte_ready"}, 32'(byte_ready), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " error"}, 32'(error), 0);
    chk({tag, " run_en"}, 32'(run_en), 0);
  endtask

  // One full programming session; expected outcome comes from summing written vs read-back bytes.
  task automatic run_session(input sess_t s);
    logic [7:0] wsum, rsum;
    int gap;
    bit exp_ok;
    for (int i = 0; i < 16; i++) stim[i] = s.ramp ? 8'(i + 1) : 8'($urandom_range(0, 255));
    wsum = 8'h00;
    rsum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      wsum = wsum + stim[i];
      rsum = rsum + ((s.corrupt && i == 5) ? stim[i] + 8'd1 : stim[i]);
    end
    exp_ok  = (wsum == rsum);
    corrupt = s.corrupt;

    @(negedge clk); prog_start = 1'b1;
    @(negedge clk); prog_start = 1'b0;
    #1;
    chk("clear mem_clr", 32'(mem_if.mem_clr), 1);
    chk("clear busy", 32'(busy), 1);
    chk("clear done", 32'(done), 0);
    chk("clear byte_ready", 32'(byte_ready), 0);

    for (int idx = 0; idx < 16; idx++) begin
      gap = s.fixed_gap ? s.max_gap : int'($urandom_range(0, s.max_gap));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'($urandom_range(0, 255));
        #1;
        chk("stall no write", 32'(mem_if.mem_low_load), 1);
        chk("stall addr held", 32'(mem_if.mem_addr), 32'(idx));
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = stim[idx];
      #1;
      chk("write addr", 32'(mem_if.mem_addr), 32'(idx));
      chk("write strobe", 32'(mem_if.mem_low_load), 0);
      chk("write data", 32'(mem_if.mem_data_in), 32'(stim[idx]));
      chk("write ready", 32'(byte_ready), 1);
    end
    @(negedge clk);
    byte_valid = 1'b0;

    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      prog_start = (s.pulse_verify && k == 8);
      #1;
      chk("verify addr", 32'(mem_if.mem_addr), 32'(k));
      chk("verify oen", 32'(mem_if.mem_low_o_en), 0);
      chk("verify busy", 32'(busy), 1);
      chk("verify done", 32'(done), 0);
    end
    @(negedge clk);
    prog_start = 1'b0;
    #1;
    chk("end done", 32'(done), 32'(exp_ok));
    chk("end run_en", 32'(run_en), 32'(exp_ok));
    chk("end error", 32'(error), 32'(!exp_ok));
    chk("end busy", 32'(busy), 0);
    chk("end low_load", 32'(mem_if.mem_low_load), 1);
    for (int i = 0; i < 16; i++) chk("mem contents", 32'(mem[i]), 32'(stim[i]));
    corrupt = 1'b0;
  endtask

  initial begin
    sessions[0] = '{max_gap: 0, fixed_gap: 1, ramp: 1, corrupt: 0, pulse_verify: 0};
    sessions[1] = '{max_gap: 3, fixed_gap: 1, ramp: 1, corrupt: 0, pulse_verify: 0};
    sessions[2] = '{max_gap: 0, fixed_gap: 1, ramp: 1, corrupt: 1, pulse_verify: 0};
    sessions[3] = '{max_gap: 0, fixed_gap: 1, ramp: 1, corrupt: 0, pulse_verify: 1};
    sessions[4] = '{max_gap: 4, fixed_gap: 0, ramp: 0, corrupt: 0, pulse_verify: 0};
    sessions[5] = '{max_gap: 2, fixed_gap: 0, ramp: 0, corrupt: 1, pulse_verify: 0};
    sessions[6] = '{max_gap: 3, fixed_gap: 0, ramp: 0, corrupt: 0, pulse_verify: 1};
    sessions[7] = '{max_gap: 0, fixed_gap: 1, ramp: 0, corrupt: 0, pulse_verify: 0};

    run_vecs[0] = '{addr: 4'hA, oen: 1'b0, exp_addr: 4'hA, exp_oen: 1'b0, exp_data: 8'h0B};
    run_vecs[1] = '{addr: 4'h0, oen: 1'b0, exp_addr: 4'h0, exp_oen: 1'b0, exp_data: 8'h01};
    run_vecs[2] = '{addr: 4'hF, oen: 1'b0, exp_addr: 4'hF, exp_oen: 1'b0, exp_data: 8'h10};
    run_vecs[3] = '{addr: 4'h3, oen: 1'b1, exp_addr: 4'h3, exp_oen: 1'b1, exp_data: 8'h00};
    run_vecs[4] = '{addr: 4'h7, oen: 1'b0, exp_addr: 4'h7, exp_oen: 1'b0, exp_data: 8'h08};

    #2;
    chk_reset_outputs("reset");
    @(negedge clk); low_clr = 1'b1;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = 8'hA5;
    #1;
    chk("idle byte_ready", 32'(byte_ready), 0);
    chk("idle no write", 32'(mem_if.mem_low_load), 1);
    @(negedge clk);
    byte_valid = 1'b0;
    #1;
    chk("idle stays idle", 32'(busy), 0);

    run_session(sessions[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpu_addr     = run_vecs[i].addr;
      cpu_low_o_en = run_vecs[i].oen;
      #1;
      chk("run addr", 32'(mem_if.mem_addr), 32'(run_vecs[i].exp_addr));
      chk("run oen", 32'(mem_if.mem_low_o_en), 32'(run_vecs[i].exp_oen));
      chk("run data", 32'(mem_if.mem_data_out), 32'(run_vecs[i].exp_data));
      chk("run low_load", 32'(mem_if.mem_low_load), 1);
      chk("run done", 32'(done), 1);
    end
    @(negedge clk);
    cpu_addr     = 4'h0;
    cpu_low_o_en = 1'b1;

    for (int i = 1; i < 8; i++) run_session(sessions[i]);

    // Reset asserted mid-write while address 7 is on the bus.
    @(negedge clk); prog_start = 1'b1;
    @(negedge clk); prog_start = 1'b0;
    for (int idx = 0; idx < 8; idx++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = 8'(idx + 1);
    end
    #1;
    chk("pre-reset addr", 32'(mem_if.mem_addr), 7);
    low_clr = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    @(negedge clk);
    byte_valid = 1'b0;
    low_clr    = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("after release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
